// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between N producers, the round-robin arbiter and one sink.
// The master side drives requests and out_ready; the slave side is the arbiter.
interface rr_mux_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter steering one of N requesters into a single output register.
// The scan starts at ptr, and ptr moves just past the granted index.
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst,
  rr_mux_arbiter_if.slave    bus
);
  localparam int PW = $clog2(N);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic [W-1:0]  data_reg, data_next;
  logic [PW-1:0] src_reg, src_next;

  logic [W-1:0]  words [N];
  logic [PW-1:0] grant;
  logic          any_valid;
  logic          can_accept;
  logic          xfer;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_word
      assign words[gi] = bus.req_data[gi*W +: W];
      assign bus.req_ready[gi] = xfer && (grant == PW'(gi));
    end
  endgenerate

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    logic [PW:0] idx;
    idx   = '0;
    grant = ptr_reg;
    for (int i = N - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_reg} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) begin
        idx = idx - (PW+1)'(N);
      end
      if (bus.req_valid[idx[PW-1:0]]) begin
        grant = idx[PW-1:0];
      end
    end
  end

  assign any_valid  = |bus.req_valid;
  assign can_accept = (state_reg == EMPTY) || bus.out_ready;
  // rst gates the grant so no requester sees ready while reset is held.
  assign xfer       = can_accept && any_valid && rst;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    data_next  = data_reg;
    src_next   = src_reg;
    case (state_reg)
      EMPTY: begin
        if (xfer) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (!xfer && bus.out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (xfer) begin
      data_next = words[grant];
      src_next  = grant;
      ptr_next  = (grant == PW'(N - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
      ptr_reg   <= '0;
      data_reg  <= '0;
      src_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      data_reg  <= data_next;
      src_reg   <= src_next;
    end
  end

  assign bus.out_valid = (state_reg == FULL);
  assign bus.out_data  = data_reg;
  assign bus.out_src   = src_reg;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios with literal expectations,
// then random traffic checked each cycle against a cyclic-scan reference model.
module tb_rr_mux_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam logic [N*W-1:0] D0 = 32'h135A1110;
  localparam logic [N*W-1:0] DS = 32'h13121110;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state
  int          m_ptr;
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_src;
  int          g;
  bit          any, can;
  logic [N-1:0] exp_ready;

  rr_mux_arbiter_if #(.N(N), .W(W)) bus ();

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare outputs to the model, then advance the model by the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      chk("rst_out_src",   32'(bus.out_src),   32'd0);
    end else begin
      any = (bus.req_valid != '0);
      can = !m_valid || bus.out_ready;
      g = 0;
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[(m_ptr + i) % N]) begin
          g = (m_ptr + i) % N;
          break;
        end
      end
      exp_ready = '0;
      if (can && any) exp_ready[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out_data",  32'(bus.out_data),  32'(m_data));
      chk("out_src",   32'(bus.out_src),   32'(m_src));
      if (can && any) begin
        m_data  = bus.req_data[g*W +: W];
        m_src   = g;
        m_valid = 1;
        m_ptr   = (g + 1) % N;
        $display("xfer src=%0d data=%02h t=%0t", g, m_data, $time);
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic ordy, input logic [N*W-1:0] d);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.out_ready = ordy;
    bus.req_data  = d;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // single request
    drive(4'b0100, 1'b1, D0);
    chk("single_ready", 32'(bus.req_ready), 32'b0100);
    // skip and wrap
    drive(4'b0011, 1'b1, DS);
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data",  32'(bus.out_data),  32'h5A);
    chk("single_src",   32'(bus.out_src),   32'd2);
    chk("skip_ready0",  32'(bus.req_ready), 32'b0001);
    drive(4'b0011, 1'b1, DS);
    chk("skip_src0",    32'(bus.out_src),   32'd0);
    chk("skip_data0",   32'(bus.out_data),  32'h10);
    chk("skip_ready1",  32'(bus.req_ready), 32'b0010);
    drive(4'b1000, 1'b1, DS);
    chk("skip_src1",    32'(bus.out_src),   32'd1);
    chk("skip_ready3",  32'(bus.req_ready), 32'b1000);
    drive(4'b1111, 1'b1, DS);
    chk("skip_src3",    32'(bus.out_src),   32'd3);
    chk("skip_data3",   32'(bus.out_data),  32'h13);
    chk("wrap_ready",   32'(bus.req_ready), 32'b0001);
    // full round-robin
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b1, DS);
      chk("rr_valid", 32'(bus.out_valid), 32'd1);
      chk("rr_src",   32'(bus.out_src),   32'(i % 4));
      chk("rr_data",  32'(bus.out_data),  32'(8'h10 + i % 4));
    end
    // backpressure
    for (int j = 0; j < 3; j++) begin
      drive(4'b1111, 1'b0, DS);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_src",   32'(bus.out_src),   32'd1);
      chk("bp_data",  32'(bus.out_data),  32'h11);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
    end
    drive(4'b1111, 1'b1, DS);
    chk("bp_release_ready", 32'(bus.req_ready), 32'b0100);
    // drain to empty
    drive(4'b0000, 1'b1, DS);
    chk("bp_next_src",  32'(bus.out_src),   32'd2);
    chk("bp_next_data", 32'(bus.out_data),  32'h12);
    chk("drain_ready",  32'(bus.req_ready), 32'd0);
    drive(4'b0000, 1'b1, DS);
    chk("drain_valid",  32'(bus.out_valid), 32'd0);
    chk("drain_data",   32'(bus.out_data),  32'h12);
    chk("drain_src",    32'(bus.out_src),   32'd2);
    // reset mid-operation
    drive(4'b1111, 1'b0, DS);
    chk("pre_rst_ready", 32'(bus.req_ready), 32'b1000);
    drive(4'b1111, 1'b0, DS);
    chk("pre_rst_src",   32'(bus.out_src),   32'd3);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_now_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_now_data",  32'(bus.out_data),  32'd0);
    chk("rst_now_src",   32'(bus.out_src),   32'd0);
    chk("rst_now_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #2 chk("rst_hold_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk("rel_ready", 32'(bus.req_ready), 32'b0001);
    drive(4'b1111, 1'b1, DS);
    chk("rel_src",   32'(bus.out_src),   32'd0);
    chk("rel_data",  32'(bus.out_data),  32'h10);

    // random traffic with occasional asynchronous reset
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst = 1'b0;
      bus.req_valid = ($urandom_range(0, 5) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.req_data  = $urandom();
    end

    @(posedge clk);
    #1 bus.req_valid = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
